// File: rtl/alu_cmd_encoder_pkg.sv
// Shared definitions for the ALU command-issue path: lane indices, ALU_FUN
// unit-select codes and FSM state encoding. Decoder_Unit uses the same codes.
package alu_cmd_encoder_pkg;

  localparam int NUM_LANES = 4;

  // Requestor lane indices; the ALU_FUN code of a command equals its lane index.
  localparam logic [1:0] LANE_ARITH = 2'd0;
  localparam logic [1:0] LANE_LOGIC = 2'd1;
  localparam logic [1:0] LANE_CMP   = 2'd2;
  localparam logic [1:0] LANE_SHIFT = 2'd3;

  // ALU_FUN unit-select codes as seen by the ALU front end.
  typedef enum logic [1:0] {
    FUN_ARITH = 2'b00,
    FUN_LOGIC = 2'b01,
    FUN_CMP   = 2'b10,
    FUN_SHIFT = 2'b11
  } alu_fun_e;

  // Command-holding FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // One-hot lane mask for a binary lane index.
  function automatic logic [3:0] lane_onehot(input logic [1:0] idx);
    logic [3:0] mask;
    case (idx)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0010;
      2'd2:    mask = 4'b0100;
      2'd3:    mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu_cmd_encoder_rr_arbiter_4.sv
// Four-lane round-robin arbiter. Purely combinational: the search starts at
// lane (last_i + 1) mod 4 and proceeds upward with wrap, so the lane served
// most recently has the lowest priority on the next capture.
module rr_arbiter_4
  import alu_cmd_encoder_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [1:0] cand_s;
  logic       found_s;

  // Rotating priority search: first asserted lane after the last winner.
  always_comb begin
    gnt_o   = 4'b0000;
    idx_o   = 2'b00;
    found_s = 1'b0;
    cand_s  = last_i;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand_s = last_i + 2'(k + 1);
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        idx_o   = cand_s;
        gnt_o   = lane_onehot(cand_s);
      end else begin
        found_s = found_s;
      end
    end
    any_o = found_s;
  end

endmodule

// File: rtl/alu_cmd_encoder.sv
// Command-issue side of the ALU function bus. Arbitrates four requestor lanes
// round-robin, encodes the winner into ALU_FUN plus a sub-op, and holds one
// registered command until the ALU accepts it with CMD_Ready.
module alu_cmd_encoder
  import alu_cmd_encoder_pkg::*;
#(
  parameter int OP_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          REQ,
  input  logic [4*OP_W-1:0]   OP_IN,
  output logic [3:0]          GNT,
  output logic [1:0]          ALU_FUN,
  output logic [OP_W-1:0]     ALU_OP,
  output logic                CMD_Valid,
  input  logic                CMD_Ready,
  output logic [CNT_W-1:0]    ISSUE_CNT
);

  // Registered state and its next-state values.
  state_e             state_q, state_d;
  logic [1:0]         last_q,  last_d;
  logic [3:0]         gnt_q,   gnt_d;
  logic [1:0]         fun_q,   fun_d;
  logic [OP_W-1:0]    op_q,    op_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // Arbiter results and handshake qualifiers.
  logic [3:0]         arb_gnt_s;
  logic [1:0]         arb_idx_s;
  logic               arb_any_s;
  logic [OP_W-1:0]    op_sel_s;
  logic               accept_s;
  logic               capture_s;

  rr_arbiter_4 u_arb (
    .req_i  (REQ),
    .last_i (last_q),
    .gnt_o  (arb_gnt_s),
    .idx_o  (arb_idx_s),
    .any_o  (arb_any_s)
  );

  // Pick the sub-op belonging to the lane the arbiter would grant.
  always_comb begin
    op_sel_s = {OP_W{1'b0}};
    case (arb_idx_s)
      LANE_ARITH: op_sel_s = OP_IN[0*OP_W +: OP_W];
      LANE_LOGIC: op_sel_s = OP_IN[1*OP_W +: OP_W];
      LANE_CMP:   op_sel_s = OP_IN[2*OP_W +: OP_W];
      LANE_SHIFT: op_sel_s = OP_IN[3*OP_W +: OP_W];
      default:    op_sel_s = {OP_W{1'b0}};
    endcase
  end

  // FSM next state: capture in IDLE on any request, or in HOLD on the accept
  // edge (back-to-back issue); otherwise hold the command under backpressure.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = 4'b0000;
    fun_d     = fun_q;
    op_d      = op_q;
    valid_d   = valid_q;
    accept_s  = 1'b0;
    capture_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (arb_any_s) begin
          capture_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (CMD_Ready) begin
          accept_s = 1'b1;
          if (arb_any_s) begin
            capture_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          // Backpressure: command, pointer and requests all frozen.
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (capture_s) begin
      state_d = ST_HOLD;
      valid_d = 1'b1;
      gnt_d   = arb_gnt_s;
      fun_d   = arb_idx_s;
      op_d    = op_sel_s;
      last_d  = arb_idx_s;
    end else begin
      gnt_d = 4'b0000;
    end
  end

  // Issued-command counter: one step per accepted command, wraps silently.
  always_comb begin
    if (accept_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers; reset drops any held command immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= LANE_SHIFT;
      gnt_q   <= 4'b0000;
      fun_q   <= FUN_ARITH;
      op_q    <= {OP_W{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      fun_q   <= fun_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT       = gnt_q;
  assign ALU_FUN   = fun_q;
  assign ALU_OP    = op_q;
  assign CMD_Valid = valid_q;
  assign ISSUE_CNT = cnt_q;

endmodule

// File: tb/tb_alu_cmd_encoder.sv
// Self-checking bench for alu_cmd_encoder: directed scenarios with literal
// expectations, then protocol-abiding random traffic against a command-level
// reference model. A second instance with a 3-bit counter shares the stimulus.
module tb_alu_cmd_encoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  REQ;
  logic [7:0]  OP_IN;
  logic        CMD_Ready;

  logic [3:0]  GNT;
  logic [1:0]  ALU_FUN;
  logic [1:0]  ALU_OP;
  logic        CMD_Valid;
  logic [7:0]  ISSUE_CNT;

  logic [3:0]  GNT3;
  logic [1:0]  ALU_FUN3;
  logic [1:0]  ALU_OP3;
  logic        CMD_Valid3;
  logic [2:0]  ISSUE_CNT3;

  int n_cmp = 0;
  int n_bad = 0;

  alu_cmd_encoder #(.OP_W(2), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP_IN(OP_IN), .GNT(GNT),
    .ALU_FUN(ALU_FUN), .ALU_OP(ALU_OP), .CMD_Valid(CMD_Valid),
    .CMD_Ready(CMD_Ready), .ISSUE_CNT(ISSUE_CNT)
  );

  alu_cmd_encoder #(.OP_W(2), .CNT_W(3)) dut3 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP_IN(OP_IN), .GNT(GNT3),
    .ALU_FUN(ALU_FUN3), .ALU_OP(ALU_OP3), .CMD_Valid(CMD_Valid3),
    .CMD_Ready(CMD_Ready), .ISSUE_CNT(ISSUE_CNT3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (command level) ----------------
  logic       m_valid;
  logic [3:0] m_gnt;
  int         m_fun, m_op, m_last, m_cnt;

  // Round-robin choice: first requesting lane after the last winner.
  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid <= 1'b0; m_gnt <= 4'b0000; m_fun <= 0; m_op <= 0;
      m_last <= 3; m_cnt <= 0;
    end else begin
      if (m_valid && CMD_Ready) m_cnt <= m_cnt + 1;
      if ((!m_valid || CMD_Ready) && REQ != 4'b0000) begin
        m_valid <= 1'b1;
        m_fun   <= rr_pick(REQ, m_last);
        m_op    <= int'(OP_IN >> (2 * rr_pick(REQ, m_last))) & 3;
        m_last  <= rr_pick(REQ, m_last);
        m_gnt   <= 4'(1 << rr_pick(REQ, m_last));
      end else begin
        m_gnt <= 4'b0000;
        if (m_valid && CMD_Ready) m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    chk("gnt", GNT, m_gnt);
    chk("valid", CMD_Valid, m_valid);
    chk("cnt8", ISSUE_CNT, m_cnt % 256);
    chk("gnt_w3", GNT3, m_gnt);
    chk("valid_w3", CMD_Valid3, m_valid);
    chk("cnt3", ISSUE_CNT3, m_cnt % 8);
    if (m_valid) begin
      chk("fun", ALU_FUN, m_fun);
      chk("op", ALU_OP, m_op);
      chk("fun_w3", ALU_FUN3, m_fun);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 4'b0000; OP_IN = 8'h00; CMD_Ready = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", CMD_Valid, 0);
    chk("rst_gnt", GNT, 0);
    chk("rst_fun", ALU_FUN, 0);
    chk("rst_op", ALU_OP, 0);
    chk("rst_cnt", ISSUE_CNT, 0);

    // Single request on lane 2 with sub-op 11.
    REQ = 4'b0100; OP_IN = 8'b0011_0000; CMD_Ready = 1'b1;
    tick();
    chk("t1_gnt", GNT, 4); chk("t1_valid", CMD_Valid, 1);
    chk("t1_fun", ALU_FUN, 2); chk("t1_op", ALU_OP, 3);
    chk("t1_model_fun", m_fun, 2);
    REQ = 4'b0000;
    tick();
    chk("t1_cnt", ISSUE_CNT, 1); chk("t1_idle", CMD_Valid, 0);

    // All lanes held: rotation 00,01,10,11,00 with no bubbles.
    do_reset();
    REQ = 4'b1111; OP_IN = 8'($urandom); CMD_Ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_fun", ALU_FUN, k % 4);
      chk("t2_gnt", GNT, 1 << (k % 4));
      chk("t2_valid", CMD_Valid, 1);
    end
    REQ = 4'b0000;
    tick();
    chk("t2_idle", CMD_Valid, 0); chk("t2_cnt", ISSUE_CNT, 5);

    // Backpressure with lanes 0 and 1 requesting.
    do_reset();
    REQ = 4'b0011; OP_IN = 8'b0000_1001; CMD_Ready = 1'b0;
    tick();
    chk("t3_gnt0", GNT, 1); chk("t3_fun0", ALU_FUN, 0); chk("t3_op0", ALU_OP, 1);
    REQ = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_fun", ALU_FUN, 0); chk("t3_hold_valid", CMD_Valid, 1);
      chk("t3_hold_gnt", GNT, 0); chk("t3_hold_cnt", ISSUE_CNT, 0);
    end
    CMD_Ready = 1'b1;
    tick();
    chk("t3_next_fun", ALU_FUN, 1); chk("t3_next_gnt", GNT, 2);
    chk("t3_next_op", ALU_OP, 2); chk("t3_next_cnt", ISSUE_CNT, 1);
    REQ = 4'b0000;
    tick();
    chk("t3_cnt", ISSUE_CNT, 2);

    // Pointer wrap: after lane 3, lane 0 beats lane 3.
    REQ = 4'b1000;
    tick();
    chk("t4_fun3", ALU_FUN, 3);
    REQ = 4'b0000;
    tick();
    REQ = 4'b1001;
    tick();
    chk("t4_wrap_fun", ALU_FUN, 0); chk("t4_wrap_gnt", GNT, 1);
    REQ = 4'b1000;
    tick();
    chk("t4_after_fun", ALU_FUN, 3);
    REQ = 4'b0000;
    tick();

    // Asynchronous reset while a command is held.
    CMD_Ready = 1'b0; REQ = 4'b0100;
    tick();
    chk("t5_valid_pre", CMD_Valid, 1);
    REQ = 4'b0000;
    tick();
    #1 RST = 1'b1;
    #1;
    chk("t5_async_valid", CMD_Valid, 0);
    chk("t5_async_gnt", GNT, 0);
    chk("t5_async_cnt", ISSUE_CNT, 0);
    chk("t5_async_cnt3", ISSUE_CNT3, 0);
    @(posedge CLK); #1;
    RST = 1'b0; REQ = 4'b1010; CMD_Ready = 1'b1;
    tick();
    chk("t5_first_fun", ALU_FUN, 1); chk("t5_first_gnt", GNT, 2);
    REQ = 4'b1000;
    tick();
    chk("t5_second_fun", ALU_FUN, 3);
    REQ = 4'b0000;
    tick(); tick();

    // Narrow counter wrap: 7 -> 0 -> 1 over accepts 7..9.
    do_reset();
    REQ = 4'b1111; CMD_Ready = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 8)  chk("t6_cnt3_7", ISSUE_CNT3, 7);
      if (n == 9)  chk("t6_cnt3_0", ISSUE_CNT3, 0);
      if (n == 10) begin
        chk("t6_cnt3_1", ISSUE_CNT3, 1);
        chk("t6_cnt8_9", ISSUE_CNT, 9);
      end
    end
    REQ = 4'b0000;
    tick();

    // Random protocol-abiding traffic; one mid-run reset.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        RST = 1'b1; REQ = 4'b0000;
        tick();
        RST = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (REQ[i] && GNT[i]) begin
          REQ[i] = 1'b0;
        end else if (!REQ[i] && $urandom_range(2, 0) == 0) begin
          REQ[i] = 1'b1;
          OP_IN[i*2 +: 2] = 2'($urandom_range(3, 0));
        end
      end
      CMD_Ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    REQ = 4'b0000;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
